// File: rtl/booth_pkg.sv
// Shared types for the Booth multiplier controller: FSM states, addsub
// encodings and the datapath control word.
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_M = 3'd1,
        LOAD_Q = 3'd2,
        CHECK  = 3'd3,
        ARITH  = 3'd4,
        SHIFT  = 3'd5,
        DONE   = 3'd6
    } state_e;

    localparam logic ADD = 1'b1;
    localparam logic SUB = 1'b0;

    typedef struct packed {
        logic ld_a;
        logic ld_q;
        logic ld_m;
        logic clr_a;
        logic clr_q;
        logic clr_ff;
        logic sft_a;
        logic sft_q;
        logic decr;
        logic ld_cnt;
        logic addsub;
    } ctrl_t;

    // Booth pair {Q0,Q-1}: 01 adds M, 10 subtracts M; only used when the bits differ.
    function automatic logic recode_op(input logic qm1_bit);
        return qm1_bit ? ADD : SUB;
    endfunction

endpackage

// File: rtl/booth_ctrl_decode.sv
// Combinational decode of FSM state into the Booth datapath control word.
module booth_ctrl_decode
    import booth_pkg::*;
(
    input  state_e state,
    input  logic   in_valid,
    input  logic   addsub_q,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.addsub = addsub_q;
        case (state)
            LOAD_M: begin
                // Multiplicand load also initialises A, Q, Q-1 and the counter.
                if (in_valid) begin
                    ctrl.ld_m   = 1'b1;
                    ctrl.clr_a  = 1'b1;
                    ctrl.clr_q  = 1'b1;
                    ctrl.clr_ff = 1'b1;
                    ctrl.ld_cnt = 1'b1;
                end
            end
            LOAD_Q: begin
                if (in_valid) begin
                    ctrl.ld_q = 1'b1;
                end
            end
            ARITH: begin
                ctrl.ld_a = 1'b1;
            end
            SHIFT: begin
                ctrl.sft_a = 1'b1;
                ctrl.sft_q = 1'b1;
                ctrl.decr  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/booth_ctrl.sv
// Control FSM for the 16-bit Booth multiplier datapath.
// Define BOOTH_ABORT_EN to add the abort input and its cancel logic.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int unsigned ITER_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    input  logic q0,
    input  logic qm1,
    input  logic eqz,
`ifdef BOOTH_ABORT_EN
    input  logic abort,
`endif
    output logic ldA,
    output logic ldQ,
    output logic ldM,
    output logic clrA,
    output logic clrQ,
    output logic clrff,
    output logic sftA,
    output logic sftQ,
    output logic decr,
    output logic ldcnt,
    output logic addsub,
    output logic busy,
    output logic done
);

    // The datapath counter must hold the iteration count of 16.
    if (ITER_W < 5) begin : g_iter_w_chk
        $error("booth_ctrl: ITER_W too narrow for 16 iterations");
    end

    state_e state_q;
    state_e state_d;
    logic   addsub_q;
    logic   addsub_d;
    logic   abort_hit;
    ctrl_t  ctrl_dec;
    ctrl_t  ctrl_out;

`ifdef BOOTH_ABORT_EN
    assign abort_hit = abort && (state_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addsub_d = addsub_q;
        case (state_q)
            IDLE:   if (start) state_d = LOAD_M;
            LOAD_M: if (in_valid) state_d = LOAD_Q;
            LOAD_Q: if (in_valid) state_d = CHECK;
            CHECK: begin
                if (!eqz) begin
                    state_d = DONE;
                end else if (q0 != qm1) begin
                    state_d  = ARITH;
                    addsub_d = recode_op(qm1);
                end else begin
                    state_d = SHIFT;
                end
            end
            ARITH:   state_d = SHIFT;
            SHIFT:   state_d = CHECK;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Cancel overrides every transition and leaves addsub untouched.
        if (abort_hit) begin
            state_d  = IDLE;
            addsub_d = addsub_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addsub_q <= SUB;
        end else begin
            state_q  <= state_d;
            addsub_q <= addsub_d;
        end
    end

    booth_ctrl_decode u_decode (
        .state    (state_q),
        .in_valid (in_valid),
        .addsub_q (addsub_q),
        .ctrl     (ctrl_dec)
    );

    always_comb begin
        ctrl_out = ctrl_dec;
        if (abort_hit) begin
            ctrl_out        = '0;
            ctrl_out.addsub = ctrl_dec.addsub;
        end
    end

    assign ldA    = ctrl_out.ld_a;
    assign ldQ    = ctrl_out.ld_q;
    assign ldM    = ctrl_out.ld_m;
    assign clrA   = ctrl_out.clr_a;
    assign clrQ   = ctrl_out.clr_q;
    assign clrff  = ctrl_out.clr_ff;
    assign sftA   = ctrl_out.sft_a;
    assign sftQ   = ctrl_out.sft_q;
    assign decr   = ctrl_out.decr;
    assign ldcnt  = ctrl_out.ld_cnt;
    assign addsub = ctrl_out.addsub;

    assign in_ready = (state_q == LOAD_M) || (state_q == LOAD_Q);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE) && !abort_hit;

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl with a behavioural 16-bit Booth datapath.
// Abort steps are compiled only when BOOTH_ABORT_EN is defined.
module tb_booth_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] data_in = '0;
    logic        in_ready;
    logic        q0, qm1, eqz;
`ifdef BOOTH_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic ldA, ldQ, ldM, clrA, clrQ, clrff, sftA, sftQ, decr, ldcnt;
    logic addsub, busy, done;
    logic [9:0] strobes;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural datapath and event counters
    logic [15:0] dp_a = '0, dp_q = '0, dp_m = '0;
    logic        dp_qm1 = 1'b0;
    logic [4:0]  dp_cnt = '0;
    logic [32:0] shifted;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    int n_ldm = 0, n_ldq = 0, n_add = 0, n_sub = 0, n_sft = 0, n_done = 0;
    int last_arith_sft = 0;

    always #5 clk = ~clk;

    booth_ctrl #(.ITER_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .q0       (q0),
        .qm1      (qm1),
        .eqz      (eqz),
`ifdef BOOTH_ABORT_EN
        .abort    (abort),
`endif
        .ldA      (ldA),
        .ldQ      (ldQ),
        .ldM      (ldM),
        .clrA     (clrA),
        .clrQ     (clrQ),
        .clrff    (clrff),
        .sftA     (sftA),
        .sftQ     (sftQ),
        .decr     (decr),
        .ldcnt    (ldcnt),
        .addsub   (addsub),
        .busy     (busy),
        .done     (done)
    );

    assign strobes = {ldA, ldQ, ldM, clrA, clrQ, clrff, sftA, sftQ, decr, ldcnt};
    assign q0      = dp_q[0];
    assign qm1     = dp_qm1;
    assign eqz     = (dp_cnt != 5'd0);
    assign shifted = {dp_a[15], dp_a, dp_q};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clrA)  dp_a   <= '0;
        if (clrQ)  dp_q   <= '0;
        if (clrff) dp_qm1 <= 1'b0;
        if (ldcnt) dp_cnt <= 5'd16;
        if (ldM)   dp_m   <= data_in;
        if (ldQ)   dp_q   <= data_in;
        if (ldA)   dp_a   <= addsub ? dp_a + dp_m : dp_a - dp_m;
        if (sftA) begin
            dp_a   <= shifted[32:17];
            dp_q   <= shifted[16:1];
            dp_qm1 <= shifted[0];
        end
        if (decr)  dp_cnt <= dp_cnt - 5'd1;
        if (ldM)   n_ldm <= n_ldm + 1;
        if (ldQ)   n_ldq <= n_ldq + 1;
        if (ldA && addsub)  n_add <= n_add + 1;
        if (ldA && !addsub) n_sub <= n_sub + 1;
        if (ldA)   last_arith_sft <= n_sft;
        if (sftA)  n_sft <= n_sft + 1;
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (rst_n && start && !busy) start_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start a multiply and feed M then Q, with optional in_valid stalls.
    task automatic run_mult(input logic [15:0] m, input logic [15:0] q,
                            input int stall_m, input int stall_q);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < stall_m; i++) begin
            in_valid = 1'b0; #1;
            check("stall_m_ready", 32'(in_ready), 32'd1);
            check("stall_m_strobes", 32'(strobes), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b1; data_in = m;
        @(negedge clk);
        in_valid = 1'b0; data_in = '0;
        for (int i = 0; i < stall_q; i++) begin
            #1;
            check("stall_q_ready", 32'(in_ready), 32'd1);
            check("stall_q_strobes", 32'(strobes), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b1; data_in = q;
        @(negedge clk);
        in_valid = 1'b0; data_in = '0;
    endtask

    task automatic wait_done(input int base);
        int t = 0;
        while (n_done == base && t < 300) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [15:0] m, input logic [15:0] q,
                                 input int stall_m, input int stall_q,
                                 input logic [31:0] exp_prod, input int exp_add,
                                 input int exp_sub, input int exp_lat);
        int b_ldm = n_ldm, b_ldq = n_ldq, b_add = n_add, b_sub = n_sub;
        int b_sft = n_sft, b_done = n_done;
        run_mult(m, q, stall_m, stall_q);
        wait_done(b_done);
        @(negedge clk);
        check({tag, "_done_cnt"}, 32'(n_done - b_done), 32'd1);
        check({tag, "_ldm_cnt"},  32'(n_ldm - b_ldm), 32'd1);
        check({tag, "_ldq_cnt"},  32'(n_ldq - b_ldq), 32'd1);
        check({tag, "_add_cnt"},  32'(n_add - b_add), 32'(exp_add));
        check({tag, "_sub_cnt"},  32'(n_sub - b_sub), 32'(exp_sub));
        check({tag, "_sft_cnt"},  32'(n_sft - b_sft), 32'd16);
        check({tag, "_product"},  {dp_a, dp_q}, exp_prod);
        check({tag, "_latency"},  32'(done_cyc - start_cyc), 32'(exp_lat));
        check({tag, "_idle"},     32'(busy), 32'd0);
        if (m == 16'd3 && q == 16'hFFFE)
            check({tag, "_arith_iter2"}, 32'(last_arith_sft - b_sft), 32'd1);
    endtask

    initial begin
        int b_done;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_strobes",  32'(strobes), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_addsub",   32'(addsub), 32'd0);
        rst_n = 1'b1;

        // 3 x -2: shift, sub+shift, then 14 shifts
        run_and_check("m3_qfffe", 16'd3, 16'hFFFE, 0, 0, 32'hFFFFFFFA, 0, 1, 37);
        // Same with 3+2 cycles of in_valid stall
        run_and_check("stall", 16'd3, 16'hFFFE, 3, 2, 32'hFFFFFFFA, 0, 1, 42);
        // 0x7FFF x 0x8000: single subtract on the last iteration
        run_and_check("m7fff_q8000", 16'h7FFF, 16'h8000, 0, 0, 32'hC0008000, 0, 1, 37);

        // Reset in the first SHIFT cycle
        b_done = n_done;
        run_mult(16'd3, 16'hFFFE, 0, 0);
        @(negedge clk);
        check("pre_rst_in_shift", 32'(sftA), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_strobes",  32'(strobes), 32'd0);
        check("mid_rst_busy",     32'(busy), 32'd0);
        check("mid_rst_done",     32'(done), 32'd0);
        check("mid_rst_addsub",   32'(addsub), 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_done",  32'(n_done - b_done), 32'd0);
        run_and_check("m5_qm7", 16'd5, 16'hFFF9, 0, 0, 32'hFFFFFFDD, 1, 2, 39);

        // start pulses in CHECK, SHIFT and DONE are ignored
        b_done = n_done;
        run_mult(16'd3, 16'hFFFE, 0, 0);
        start = 1'b1;
        @(negedge clk);
        check("ign_in_shift", 32'(sftA), 32'd1);
        @(negedge clk);
        start = 1'b0;
        begin
            int t = 0;
            while (!done && t < 300) begin
                @(negedge clk);
                t++;
            end
        end
        check("ign_done_seen", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_idle_after_done", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("ign_still_idle", 32'(busy), 32'd0);
        check("ign_done_once",  32'(n_done - b_done), 32'd1);
        check("ign_product",    {dp_a, dp_q}, 32'hFFFFFFFA);

`ifdef BOOTH_ABORT_EN
        // Abort in the first ARITH cycle of 3 x -2
        b_done = n_done;
        run_mult(16'd3, 16'hFFFE, 0, 0);
        repeat (3) @(negedge clk);
        check("abort_pre_lda", 32'(ldA), 32'd1);
        abort = 1'b1; #1;
        check("abort_strobes", 32'(strobes), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle",    32'(busy), 32'd0);
        check("abort_lda_off", 32'(ldA), 32'd0);
        repeat (40) @(negedge clk);
        check("abort_never_done", 32'(n_done - b_done), 32'd0);
        run_and_check("post_abort", 16'd5, 16'hFFF9, 0, 0, 32'hFFFFFFDD, 1, 2, 39);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
